// File: rtl/spi_master.sv
// rtl/spi_master.sv - single-byte full-duplex SPI master
// Optional chip-select output o_SPI_CS_n is compiled in with `define SPI_MASTER_CS_EN.
module spi_master #(
    parameter int SPI_MODE          = 0,
    parameter int LSB_FIRST         = 0,
    parameter int CLKS_PER_HALF_BIT = 2
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [7:0] i_TX_Byte,
    input  logic       i_TX_DV,
    output logic       o_TX_Ready,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_SPI_Clk,
    input  logic       i_SPI_MISO,
    output logic       o_SPI_MOSI
`ifdef SPI_MASTER_CS_EN
    ,
    output logic       o_SPI_CS_n
`endif
);

    localparam logic CPOL = ((SPI_MODE & 2) != 0);
    localparam logic CPHA = ((SPI_MODE & 1) != 0);
    localparam int HW = $clog2(CLKS_PER_HALF_BIT);
    localparam logic [HW-1:0] HALF_LAST = HW'(CLKS_PER_HALF_BIT - 1);
    localparam logic [4:0] EDGES_TOTAL = 5'd16;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t state;
    state_t state_next;

    logic [HW-1:0] half_cnt;
    logic [4:0]    edge_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    tx_reg;
    logic [7:0]    rx_shift;

    logic accept;
    logic done;
    logic sclk_edge;
    logic leading;
    logic trailing;
    logic sample;
    logic shift_out;

    // Transfer-order index i maps to byte bit i (LSB first) or 7-i (MSB first).
    function automatic logic pick(input logic [7:0] b, input logic [2:0] i);
        return (LSB_FIRST != 0) ? b[i] : b[~i];
    endfunction

    // edge_cnt holds the number of SCLK edges already produced, so an even
    // count means the edge about to be registered is a leading one.
    assign accept    = (state == IDLE) && i_TX_DV;
    assign done      = (state == BUSY) && (edge_cnt == EDGES_TOTAL);
    assign sclk_edge = (state == BUSY) && (half_cnt == HALF_LAST) && !done;
    assign leading   = sclk_edge && !edge_cnt[0];
    assign trailing  = sclk_edge && edge_cnt[0];
    assign sample    = CPHA ? trailing : leading;
    assign shift_out = CPHA ? leading : (trailing && (edge_cnt != 5'd15));

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        o_TX_Ready = 1'b0;
        case (state)
            IDLE: begin
                o_TX_Ready = 1'b1;
                if (i_TX_DV) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            o_SPI_Clk  <= CPOL;
            o_SPI_MOSI <= 1'b0;
            o_RX_DV    <= 1'b0;
            o_RX_Byte  <= 8'h00;
            half_cnt   <= '0;
            edge_cnt   <= 5'd0;
            bit_idx    <= 3'd0;
            tx_reg     <= 8'h00;
            rx_shift   <= 8'h00;
        end else begin
            o_RX_DV <= 1'b0;
            if (accept) begin
                tx_reg    <= i_TX_Byte;
                half_cnt  <= HW'(1);
                edge_cnt  <= 5'd0;
                o_SPI_Clk <= CPOL;
                rx_shift  <= 8'h00;
                // CPHA=0 must present the first bit before the first leading edge.
                if (!CPHA) begin
                    o_SPI_MOSI <= pick(i_TX_Byte, 3'd0);
                    bit_idx    <= 3'd1;
                end else begin
                    bit_idx    <= 3'd0;
                end
            end else if (done) begin
                o_RX_Byte <= rx_shift;
                o_RX_DV   <= 1'b1;
            end else if (state == BUSY) begin
                half_cnt <= (half_cnt == HALF_LAST) ? '0 : half_cnt + HW'(1);
                if (sclk_edge) begin
                    o_SPI_Clk <= ~o_SPI_Clk;
                    edge_cnt  <= edge_cnt + 5'd1;
                end
                if (sample) begin
                    rx_shift <= (LSB_FIRST != 0) ? {i_SPI_MISO, rx_shift[7:1]}
                                                 : {rx_shift[6:0], i_SPI_MISO};
                end
                if (shift_out) begin
                    o_SPI_MOSI <= pick(tx_reg, bit_idx);
                    bit_idx    <= bit_idx + 3'd1;
                end
            end
        end
    end

`ifdef SPI_MASTER_CS_EN
    // Busy spans exactly cycles 1..16N, so chip select is the inverse of busy.
    assign o_SPI_CS_n = o_TX_Ready;
`endif

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - self-checking bench for spi_master across three mode/order/rate configurations
module tb_spi_master;

    logic            clk;
    logic [2:0]      rst;
    logic [2:0][7:0] txb;
    logic [2:0]      dv_in;
    logic [2:0]      ready;
    logic [2:0]      rxdv;
    logic [2:0][7:0] rxb;
    logic [2:0]      sclk;
    logic [2:0]      miso;
    logic [2:0]      mosi;
    logic [2:0]      loop_en;
    logic [2:0]      slave_bit;
`ifdef SPI_MASTER_CS_EN
    logic [2:0]      cs_n;
`endif

    int checks;
    int errors;
    bit pending;

    assign miso = (loop_en & mosi) | (~loop_en & slave_bit);

    spi_master #(.SPI_MODE(3), .LSB_FIRST(1), .CLKS_PER_HALF_BIT(4)) u_dut0 (
        .i_Clk(clk), .i_Rst(rst[0]), .i_TX_Byte(txb[0]), .i_TX_DV(dv_in[0]),
        .o_TX_Ready(ready[0]), .o_RX_DV(rxdv[0]), .o_RX_Byte(rxb[0]),
        .o_SPI_Clk(sclk[0]), .i_SPI_MISO(miso[0]), .o_SPI_MOSI(mosi[0])
`ifdef SPI_MASTER_CS_EN
        , .o_SPI_CS_n(cs_n[0])
`endif
    );

    spi_master #(.SPI_MODE(0), .LSB_FIRST(0), .CLKS_PER_HALF_BIT(2)) u_dut1 (
        .i_Clk(clk), .i_Rst(rst[1]), .i_TX_Byte(txb[1]), .i_TX_DV(dv_in[1]),
        .o_TX_Ready(ready[1]), .o_RX_DV(rxdv[1]), .o_RX_Byte(rxb[1]),
        .o_SPI_Clk(sclk[1]), .i_SPI_MISO(miso[1]), .o_SPI_MOSI(mosi[1])
`ifdef SPI_MASTER_CS_EN
        , .o_SPI_CS_n(cs_n[1])
`endif
    );

    spi_master #(.SPI_MODE(1), .LSB_FIRST(0), .CLKS_PER_HALF_BIT(3)) u_dut2 (
        .i_Clk(clk), .i_Rst(rst[2]), .i_TX_Byte(txb[2]), .i_TX_DV(dv_in[2]),
        .o_TX_Ready(ready[2]), .o_RX_DV(rxdv[2]), .o_RX_Byte(rxb[2]),
        .o_SPI_Clk(sclk[2]), .i_SPI_MISO(miso[2]), .o_SPI_MOSI(mosi[2])
`ifdef SPI_MASTER_CS_EN
        , .o_SPI_CS_n(cs_n[2])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int mode_of(input int d);
        return (d == 0) ? 3 : ((d == 1) ? 0 : 1);
    endfunction

    function automatic int lsb_of(input int d);
        return (d == 0) ? 1 : 0;
    endfunction

    function automatic int n_of(input int d);
        return (d == 0) ? 4 : ((d == 1) ? 2 : 3);
    endfunction

    function automatic logic pbit(input logic [7:0] b, input int lsb, input int i);
        return (lsb != 0) ? b[i] : b[7-i];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_check(input int d, input int ncyc);
        int extra_dv;
        int low;
        extra_dv = 0;
        low = 0;
        repeat (ncyc) begin
            @(negedge clk);
            if (rxdv[d]) extra_dv++;
            if (!ready[d]) low++;
        end
        chk("extra_rx_dv", 32'(extra_dv), 32'd0);
        chk("idle_ready_low", 32'(low), 32'd0);
    endtask

    // One byte exchange against an ideal SPI slave: the slave shifts pat out
    // and assembles what it sees on MOSI; loopback replaces pat by tx.
    task automatic xfer(input int d, input logic [7:0] tx, input bit loop,
                        input logic [7:0] pat, input int inject_at, input int abort_at,
                        input bit chain, input logic [7:0] next_tx);
        int n, cpha, cpol, lsb;
        int busy, edges, dvs, dv_cyc, ci, si, cs_low, cs_bad;
        logic prev, rdy_dv, sclk_dv;
        logic [7:0] got_mosi, exp_rx, rx_at_dv;
        logic ab_rdy, ab_sclk, ab_mosi, ab_dv;
        logic [7:0] ab_rxb;
        n = n_of(d);
        cpha = mode_of(d) & 1;
        cpol = (mode_of(d) >> 1) & 1;
        lsb = lsb_of(d);
        busy = 0; edges = 0; dvs = 0; dv_cyc = 0; ci = 0; si = 0; cs_low = 0; cs_bad = 0;
        rdy_dv = 1'b0; sclk_dv = 1'bx; rx_at_dv = 8'hxx; got_mosi = 8'h00;
        ab_rdy = 1'b0; ab_sclk = 1'bx; ab_mosi = 1'bx; ab_dv = 1'bx; ab_rxb = 8'hxx;
        loop_en[d] = loop;
        exp_rx = loop ? tx : pat;
        if (cpha == 0) begin
            slave_bit[d] = pbit(pat, lsb, 0);
            si = 1;
        end
        if (!pending) begin
            @(negedge clk);
            dv_in[d] = 1'b1;
            txb[d] = tx;
        end
        pending = 1'b0;
        prev = sclk[d];
        @(posedge clk);
        for (int cyc = 1; cyc <= 16 * n + 4; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                dv_in[d] = 1'b0;
                if (cpha == 0) chk("mosi_first_bit", 32'(mosi[d]), 32'(pbit(tx, lsb, 0)));
            end
            if (inject_at != 0 && cyc == inject_at) begin
                dv_in[d] = 1'b1;
                txb[d] = 8'h3C;
            end
            if (inject_at != 0 && cyc == inject_at + 1) dv_in[d] = 1'b0;
            if (abort_at != 0 && cyc == abort_at + 1) begin
                ab_rdy = ready[d]; ab_sclk = sclk[d]; ab_mosi = mosi[d];
                ab_rxb = rxb[d]; ab_dv = rxdv[d];
                rst[d] = 1'b0;
                break;
            end
            if (abort_at != 0 && cyc == abort_at) rst[d] = 1'b1;
            if (!ready[d]) busy++;
`ifdef SPI_MASTER_CS_EN
            if (!cs_n[d]) cs_low++;
            if (cs_n[d] !== ready[d]) cs_bad++;
`endif
            if (sclk[d] !== prev) begin
                edges++;
                prev = sclk[d];
                if ((edges % 2 == 1) == (cpha == 0)) begin
                    if (ci < 8) got_mosi[(lsb != 0) ? ci : 7 - ci] = mosi[d];
                    ci++;
                end else if (si < 8 && edges < 16) begin
                    slave_bit[d] = pbit(pat, lsb, si);
                    si++;
                end
            end
            if (rxdv[d]) begin
                dvs++;
                dv_cyc = cyc;
                rdy_dv = ready[d];
                sclk_dv = sclk[d];
                rx_at_dv = rxb[d];
                if (chain) begin
                    dv_in[d] = 1'b1;
                    txb[d] = next_tx;
                    pending = 1'b1;
                end
                break;
            end
        end
        if (abort_at != 0) begin
            chk("abort_rx_dv_count", 32'(dvs), 32'd0);
            chk("abort_ready", 32'(ab_rdy), 32'd1);
            chk("abort_sclk", 32'(ab_sclk), 32'(cpol));
            chk("abort_mosi", 32'(ab_mosi), 32'd0);
            chk("abort_rx_byte", 32'(ab_rxb), 32'h00);
            chk("abort_rx_dv", 32'(ab_dv), 32'd0);
        end else begin
            chk("busy_cycles", 32'(busy), 32'(16 * n));
            chk("rx_dv_cycle", 32'(dv_cyc), 32'(16 * n + 1));
            chk("sclk_edges", 32'(edges), 32'd16);
            chk("ready_at_done", 32'(rdy_dv), 32'd1);
            chk("sclk_idle_at_done", 32'(sclk_dv), 32'(cpol));
            chk("rx_byte", 32'(rx_at_dv), 32'(exp_rx));
            chk("mosi_byte", 32'(got_mosi), 32'(tx));
`ifdef SPI_MASTER_CS_EN
            chk("cs_low_cycles", 32'(cs_low), 32'(16 * n));
            chk("cs_vs_busy", 32'(cs_bad), 32'd0);
`endif
        end
    endtask

    initial begin
        logic [7:0] rtx, rpat;
        int rd;
        bit rloop;
        checks = 0;
        errors = 0;
        pending = 1'b0;
        rst = 3'b111;
        txb = '0;
        dv_in = 3'b000;
        loop_en = 3'b000;
        slave_bit = 3'b000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("reset_ready", 32'(ready[d]), 32'd1);
            chk("reset_rx_dv", 32'(rxdv[d]), 32'd0);
            chk("reset_rx_byte", 32'(rxb[d]), 32'h00);
            chk("reset_sclk", 32'(sclk[d]), 32'((mode_of(d) >> 1) & 1));
            chk("reset_mosi", 32'(mosi[d]), 32'd0);
`ifdef SPI_MASTER_CS_EN
            chk("reset_cs_n", 32'(cs_n[d]), 32'd1);
`endif
        end
        rst = 3'b000;

        xfer(0, 8'hC1, 1'b1, 8'h00, 0, 0, 1'b0, 8'h00);
        idle_check(0, 10);

        xfer(0, 8'hB1, 1'b1, 8'h00, 0, 0, 1'b1, 8'hE2);
        xfer(0, 8'hE2, 1'b1, 8'h00, 0, 0, 1'b0, 8'h00);
        idle_check(0, 10);

        xfer(1, 8'hA5, 1'b0, 8'hFF, 0, 0, 1'b0, 8'h00);
        xfer(1, 8'hA5, 1'b0, 8'h00, 0, 0, 1'b0, 8'h00);
        idle_check(1, 6);

        xfer(0, 8'h81, 1'b1, 8'h00, 30, 0, 1'b0, 8'h00);
        idle_check(0, 80);

        xfer(0, 8'h96, 1'b1, 8'h00, 0, 20, 1'b0, 8'h00);
        idle_check(0, 10);
        xfer(0, 8'h5A, 1'b1, 8'h00, 0, 0, 1'b0, 8'h00);

        xfer(2, 8'h0F, 1'b1, 8'h00, 0, 0, 1'b0, 8'h00);
        idle_check(2, 5);

        for (int i = 0; i < 9; i++) begin
            rd = $urandom_range(0, 2);
            rtx = 8'($urandom);
            rpat = 8'($urandom);
            rloop = 1'($urandom_range(0, 1));
            xfer(rd, rtx, rloop, rpat, 0, 0, 1'b0, 8'h00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
